heap_mem_server: RTL and testbench

HEAP_MEM_SERVER -- requirements
Module: heap_mem_server

---
 rtl/heap_mem_server.sv | 137 +++++++++++++
 tb/tb_heap_mem_server.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/heap_mem_server.sv
// Tagged-word heap memory: fixed-latency reads plus bump-pointer allocating writes.
// A write that collides with an in-flight read is parked in a one-entry buffer.
module heap_mem_server #(
    parameter int unsigned ADDR_W       = 12,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned HEAP_BASE    = 'h100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_out,
    input  logic              write_enable,
    input  logic [DATA_W-1:0] write_data,
    output logic [ADDR_W-1:0] write_result_addr,
    output logic              write_done,
    output logic              busy,
    output logic              heap_full
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(READ_LATENCY - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(HEAP_BASE);

    typedef enum logic [1:0] {IDLE, READ, WRITE_PEND} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] free_ptr;
    logic              pend_valid;
    logic [DATA_W-1:0] pend_data;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              pend_take;

    // Store happens either directly from IDLE or when draining the parked write.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = write_data;
        if (!heap_full) begin
            if (state == IDLE && write_enable && !req) begin
                mem_we = 1'b1;
            end else if (state == WRITE_PEND && pend_valid) begin
                mem_we    = 1'b1;
                mem_wdata = pend_data;
            end
        end
    end

    assign pend_take = (state == READ) && write_enable && !pend_valid && !heap_full;
    assign busy      = (state != IDLE) || pend_valid;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[free_ptr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            cnt               <= '0;
            rd_addr           <= '0;
            free_ptr          <= BASE_ADDR;
            pend_valid        <= 1'b0;
            pend_data         <= '0;
            data_ready        <= 1'b0;
            data_out          <= '0;
            write_done        <= 1'b0;
            write_result_addr <= '0;
            heap_full         <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            write_done <= 1'b0;

            // Allocation pointer saturates at the top; the last slot sets heap_full.
            if (mem_we) begin
                write_result_addr <= free_ptr;
                write_done        <= 1'b1;
                if (free_ptr == LAST_ADDR) begin
                    heap_full <= 1'b1;
                end else begin
                    free_ptr <= free_ptr + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= READ;
                        rd_addr <= addr_in;
                        cnt     <= CNT_LOAD;
                        if (CNT_LOAD == '0) begin
                            data_ready <= 1'b1;
                            data_out   <= mem[addr_in];
                        end
                        if (write_enable && !heap_full) begin
                            pend_valid <= 1'b1;
                            pend_data  <= write_data;
                        end
                    end
                end
                READ: begin
                    if (pend_take) begin
                        pend_valid <= 1'b1;
                        pend_data  <= write_data;
                    end
                    // Strobe is raised on the edge the counter reaches zero.
                    if (cnt == '0) begin
                        state <= (pend_valid || pend_take) ? WRITE_PEND : IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            data_ready <= 1'b1;
                            data_out   <= mem[rd_addr];
                        end
                    end
                end
                WRITE_PEND: begin
                    pend_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_heap_mem_server.sv
// Randomized bench for heap_mem_server against a transaction-level timing/allocation model.
module tb_heap_mem_server;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [11:0] addr_in;
    logic        data_ready;
    logic [15:0] data_out;
    logic        write_enable;
    logic [15:0] write_data;
    logic [11:0] write_result_addr;
    logic        write_done;
    logic        busy;
    logic        heap_full;

    heap_mem_server #(
        .ADDR_W(12), .DATA_W(16), .READ_LATENCY(L), .HEAP_BASE('h100)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .addr_in(addr_in),
        .data_ready(data_ready), .data_out(data_out),
        .write_enable(write_enable), .write_data(write_data),
        .write_result_addr(write_result_addr), .write_done(write_done),
        .busy(busy), .heap_full(heap_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [15:0] v;
    } ev_t;

    ev_t         rq[$];
    ev_t         wq[$];
    logic [15:0] mem_m [4096];
    int          fp, hi, full, full_at, idle_at, acc, dr, pend;
    logic [15:0] last_d;
    logic [11:0] last_a;
    int          cyc;
    bit          chk_en;
    int          n_cmp, n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        wq.delete();
        fp = 'h100; full = 0; full_at = 1 << 30;
        idle_at = 0; acc = -10; dr = -10; pend = 0;
        last_d = '0; last_a = '0;
    endtask

    // Allocation: store at free pointer, report completion at cycle dc.
    task automatic do_write(input int dc, input logic [15:0] d);
        ev_t e;
        if (full != 0) return;
        mem_m[fp] = d;
        e.c = dc; e.v = 16'(fp);
        wq.push_back(e);
        if (fp + 1 > hi) hi = fp + 1;
        if (fp == 'hFFF) begin
            full = 1; full_at = dc;
        end else begin
            fp++;
        end
    endtask

    task automatic park(input logic [15:0] d);
        if (full == 0) begin
            pend = 1;
            do_write(dr + 2, d);
            idle_at = dr + 2;
        end
    endtask

    task automatic drive(input logic r, input logic [11:0] a, input logic w, input logic [15:0] d);
        ev_t e;
        int  n;
        n = cyc;
        req = r; addr_in = a; write_enable = w; write_data = d;
        if (n >= idle_at) begin
            if (r) begin
                e.c = n + L; e.v = mem_m[a];
                rq.push_back(e);
                acc = n; dr = n + L; pend = 0; idle_at = n + L + 1;
                if (w) park(d);
            end else if (w) begin
                do_write(n + 1, d);
            end
        end else if (w && n > acc && n <= dr && pend == 0) begin
            park(d);
        end
        @(posedge clk);
        #1;
        cyc++;
        req = 1'b0; write_enable = 1'b0;
    endtask

    function automatic logic [11:0] pick_addr();
        return 12'('h100 + ($urandom % 32'(hi - 'h100)));
    endfunction

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            bit exp_dr, exp_wd;
            exp_dr = (rq.size() > 0) && (rq[0].c == cyc);
            check("data_ready", 32'(data_ready), 32'(exp_dr));
            if (exp_dr) last_d = rq[0].v;
            if (rq.size() > 0 && rq[0].c <= cyc) void'(rq.pop_front());
            check("data_out", 32'(data_out), 32'(last_d));

            exp_wd = (wq.size() > 0) && (wq[0].c == cyc);
            check("write_done", 32'(write_done), 32'(exp_wd));
            if (exp_wd) last_a = 12'(wq[0].v);
            if (wq.size() > 0 && wq[0].c <= cyc) void'(wq.pop_front());
            check("write_result_addr", 32'(write_result_addr), 32'(last_a));

            check("busy", 32'(busy), 32'((cyc > acc) && (cyc < idle_at)));
            check("heap_full", 32'(heap_full), 32'(cyc >= full_at));
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_data_ready"}, 32'(data_ready), 32'(0));
        check({tag, "_data_out"}, 32'(data_out), 32'(0));
        check({tag, "_write_done"}, 32'(write_done), 32'(0));
        check({tag, "_wr_addr"}, 32'(write_result_addr), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_heap_full"}, 32'(heap_full), 32'(0));
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) drive(1'b0, 12'h0, 1'b0, 16'h0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; chk_en = 0; hi = 'h100;
        for (int i = 0; i < 4096; i++) mem_m[i] = '0;
        model_reset();
        req = 0; addr_in = '0; write_enable = 0; write_data = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;

        // Three allocations back to back, then timed reads of them.
        drive(1'b0, 12'h0, 1'b1, 16'hAAAA);
        drive(1'b0, 12'h0, 1'b1, 16'hBBBB);
        drive(1'b0, 12'h0, 1'b1, 16'hCCCC);
        idle_cycles(2);
        drive(1'b1, 12'h100, 1'b0, 16'h0);
        idle_cycles(4);
        drive(1'b1, 12'h102, 1'b0, 16'h0);
        idle_cycles(4);
        drive(1'b1, 12'h101, 1'b0, 16'h0);
        idle_cycles(4);

        // Read with simultaneous write, then a second write that must be dropped.
        drive(1'b1, 12'h101, 1'b1, 16'h5555);
        drive(1'b0, 12'h0, 1'b1, 16'h6666);
        idle_cycles(5);

        // Reads pulsed during an in-flight read are ignored.
        drive(1'b1, 12'h100, 1'b0, 16'h0);
        drive(1'b1, 12'h102, 1'b0, 16'h0);
        drive(1'b1, 12'h101, 1'b0, 16'h0);
        idle_cycles(4);

        for (int i = 0; i < 600; i++) begin
            logic r, w;
            r = ($urandom % 4) == 0;
            w = ($urandom % 3) == 0;
            drive(r, pick_addr(), w, 16'($urandom));
        end
        idle_cycles(6);

        // Reset one cycle after a read request aborts it.
        drive(1'b1, 12'h100, 1'b0, 16'h0);
        chk_en = 0;
        rst = 1'b1;
        #2;
        check_zero("abort");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        model_reset();
        chk_en = 1;
        drive(1'b1, 12'h100, 1'b0, 16'h0);
        idle_cycles(4);
        drive(1'b0, 12'h0, 1'b1, 16'h1357);
        idle_cycles(2);

        // Fill the heap to the last slot, then confirm saturation.
        while (fp != 'hFFF) begin
            drive(($urandom % 16) == 0, pick_addr(), 1'b1, 16'($urandom));
        end
        idle_cycles(5);
        drive(1'b0, 12'h0, 1'b1, 16'h0001);
        drive(1'b0, 12'h0, 1'b0, 16'h0);
        drive(1'b0, 12'h0, 1'b1, 16'h7777);
        idle_cycles(2);
        drive(1'b1, 12'hFFF, 1'b0, 16'h0);
        idle_cycles(4);
        drive(1'b1, 12'hFFF, 1'b1, 16'h8888);
        idle_cycles(5);
        check("heap_full_sticky", 32'(heap_full), 32'(1));
        check("rd_queue_drained", 32'(rq.size()), 32'(0));
        check("wr_queue_drained", 32'(wq.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
